// File: rtl/counter_pkg.sv
// Shared definitions for the loadable up/down counter: default width and
// the direction encoding used by the up_dn control input.
package counter_pkg;

  localparam int COUNTER_DEFAULT_WIDTH = 4;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } count_dir_t;

endpackage : counter_pkg

// File: rtl/counter_4bit.sv
// Synchronous loadable binary counter with enable, up/down direction,
// combinational terminal count and a registered one-cycle wrap pulse.
module counter_4bit
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH     = COUNTER_DEFAULT_WIDTH,
  parameter int unsigned MAX_VAL   = (2 ** WIDTH) - 1,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             en,
  input  logic             up_dn,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_COUNT   = MAX_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] RESET_COUNT = RESET_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ZERO_COUNT  = '0;
  localparam logic [WIDTH-1:0] ONE_COUNT   = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic [WIDTH-1:0] w_loadValue;
  logic [WIDTH-1:0] w_nextCount;
  logic             w_nextWrap;
  count_dir_t       w_dir;

  assign w_dir = count_dir_t'(up_dn);

  // A full-range modulus can never see an out-of-range load, so the clamp
  // comparator only exists for non-power-of-two moduli.
  generate
    if (MAX_VAL == (2 ** WIDTH) - 1) begin : g_noClamp
      assign w_loadValue = load_data;
    end else begin : g_clamp
      assign w_loadValue = (load_data > MAX_COUNT) ? MAX_COUNT : load_data;
    end
  endgenerate

  always_comb begin
    w_nextCount = r_count;
    w_nextWrap  = 1'b0;
    if (load) begin
      w_nextCount = w_loadValue;
    end else if (en) begin
      if (w_dir == DIR_UP) begin
        if (r_count == MAX_COUNT) begin
          w_nextCount = ZERO_COUNT;
          w_nextWrap  = 1'b1;
        end else begin
          w_nextCount = r_count + ONE_COUNT;
        end
      end else begin
        if (r_count == ZERO_COUNT) begin
          w_nextCount = MAX_COUNT;
          w_nextWrap  = 1'b1;
        end else begin
          w_nextCount = r_count - ONE_COUNT;
        end
      end
    end
  end

  // Reset sits above load/count so an in-flight load is discarded on that edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= RESET_COUNT;
      r_wrap  <= 1'b0;
    end else begin
      r_count <= w_nextCount;
      r_wrap  <= w_nextWrap;
    end
  end

  assign count = r_count;
  assign wrap  = r_wrap;
  assign tc    = (w_dir == DIR_UP) ? (r_count == MAX_COUNT) : (r_count == ZERO_COUNT);

endmodule : counter_4bit

// File: tb/tb_counter_4bit.sv
// Directed self-checking bench for counter_4bit: a full-range instance and a
// modulo-10 instance exercising clamp and non-power-of-two wrap.
module tb_counter_4bit;

  logic       clk;
  logic       aReset, aLoad, aEn, aUpDn;
  logic [3:0] aLoadData;
  logic [3:0] aCount;
  logic       aTc, aWrap;
  logic       bReset, bLoad, bEn, bUpDn;
  logic [3:0] bLoadData;
  logic [3:0] bCount;
  logic       bTc, bWrap;

  int nChecks = 0;
  int nErrors = 0;

  counter_4bit #(.WIDTH(4)) dutA (
    .clk(clk), .reset(aReset), .load(aLoad), .load_data(aLoadData),
    .en(aEn), .up_dn(aUpDn), .count(aCount), .tc(aTc), .wrap(aWrap)
  );

  counter_4bit #(.WIDTH(4), .MAX_VAL(9), .RESET_VAL(3)) dutB (
    .clk(clk), .reset(bReset), .load(bLoad), .load_data(bLoadData),
    .en(bEn), .up_dn(bUpDn), .count(bCount), .tc(bTc), .wrap(bWrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge, then settle so sampling is well clear of the edge.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nChecks++;
    assert (observed === expected)
    else begin
      nErrors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkA(input string tag, input int expCount, input int expTc,
                        input int expWrap);
    checkOutput({tag, ".count"}, 32'(aCount), 32'(expCount));
    checkOutput({tag, ".tc"},    32'(aTc),    32'(expTc));
    checkOutput({tag, ".wrap"},  32'(aWrap),  32'(expWrap));
  endtask

  task automatic checkB(input string tag, input int expCount, input int expTc,
                        input int expWrap);
    checkOutput({tag, ".count"}, 32'(bCount), 32'(expCount));
    checkOutput({tag, ".tc"},    32'(bTc),    32'(expTc));
    checkOutput({tag, ".wrap"},  32'(bWrap),  32'(expWrap));
  endtask

  initial begin
    $display("[TB] starting counter_4bit directed sequence");
    aReset = 1'b1; aLoad = 1'b1; aLoadData = 4'd5; aEn = 1'b1; aUpDn = 1'b1;
    bReset = 1'b1; bLoad = 1'b1; bLoadData = 4'd7; bEn = 1'b1; bUpDn = 1'b1;
    #2;

    // Reset beats load and enable.
    applyStimulus();
    checkA("resetA", 0, 0, 0);
    checkB("resetB", 3, 0, 0);

    // Load held for three edges keeps the value frozen.
    aReset = 1'b0; aLoad = 1'b1; aLoadData = 4'd7;
    bReset = 1'b0; bLoad = 1'b0; bEn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkA($sformatf("loadHold%0d", i), 7, 0, 0);
    end

    aLoad = 1'b0; aEn = 1'b1; aUpDn = 1'b1;
    applyStimulus(); checkA("countUp8", 8, 0, 0);
    applyStimulus(); checkA("countUp9", 9, 0, 0);
    applyStimulus(); checkA("countUp10", 10, 0, 0);
    applyStimulus(); checkA("countUp11", 11, 0, 0);

    // Reload in the middle of counting.
    aLoad = 1'b1; aLoadData = 4'd7;
    applyStimulus(); checkA("reload7", 7, 0, 0);
    aLoad = 1'b0;
    applyStimulus(); checkA("resume8", 8, 0, 0);
    applyStimulus(); checkA("resume9", 9, 0, 0);

    // Upward wrap at 15.
    aLoad = 1'b1; aLoadData = 4'd14;
    applyStimulus(); checkA("load14", 14, 0, 0);
    aLoad = 1'b0;
    applyStimulus(); checkA("up15", 15, 1, 0);
    applyStimulus(); checkA("upWrap0", 0, 0, 1);
    applyStimulus(); checkA("up1", 1, 0, 0);

    // Downward wrap, then hold with enable low.
    aLoad = 1'b1; aLoadData = 4'd1; aUpDn = 1'b0;
    applyStimulus(); checkA("load1", 1, 0, 0);
    aLoad = 1'b0;
    applyStimulus(); checkA("down0", 0, 1, 0);
    applyStimulus(); checkA("downWrap15", 15, 0, 1);
    aEn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkA($sformatf("hold%0d", i), 15, 0, 0);
    end

    // Direction change takes effect on the next counting edge.
    aEn = 1'b1; aUpDn = 1'b1;
    applyStimulus(); checkA("dirUpWrap", 0, 0, 1);

    // Reset mid-count discards a simultaneous load.
    aReset = 1'b1; aLoad = 1'b1; aLoadData = 4'd12;
    applyStimulus(); checkA("midReset", 0, 0, 0);
    aReset = 1'b0; aLoad = 1'b0; aEn = 1'b0;

    // Modulo-10 instance: clamp, wrap up and wrap down.
    bLoad = 1'b1; bLoadData = 4'd12; bEn = 1'b1; bUpDn = 1'b1;
    applyStimulus(); checkB("clamp9", 9, 1, 0);
    bLoad = 1'b0;
    applyStimulus(); checkB("mod10Wrap0", 0, 0, 1);
    applyStimulus(); checkB("mod10Up1", 1, 0, 0);
    bLoad = 1'b1; bLoadData = 4'd8;
    applyStimulus(); checkB("mod10Load8", 8, 0, 0);
    bLoad = 1'b1; bLoadData = 4'd0; bUpDn = 1'b0;
    applyStimulus(); checkB("mod10Load0", 0, 1, 0);
    bLoad = 1'b0;
    applyStimulus(); checkB("mod10DownWrap9", 9, 0, 1);
    applyStimulus(); checkB("mod10Down8", 8, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule : tb_counter_4bit
